// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable baud divider, data width, parity and stop bits.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority voting around mid-bit.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BAUD_DIV / 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_sync, rx_hist;
    logic                 fall;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic                 bit_end;
    logic                 decide;
    logic                 bit_val;
    logic                 done;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_bad;
    logic                 stop_bad;

    // Synchroniser resets to 1 so a reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_meta, rx_sync, rx_hist} <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_hist <= rx_sync;
        end
    end

    assign fall    = rx_hist & ~rx_sync;
    assign bit_end = (cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(BAUD_DIV / 2 + 1);

    logic maj_a, maj_b;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (cnt == CNT_MID_M1) maj_a <= rx_sync;
            if (cnt == CNT_MID)    maj_b <= rx_sync;
        end
    end

    assign decide  = (cnt == CNT_MID_P1);
    assign bit_val = (maj_a & maj_b) | (maj_a & rx_sync) | (maj_b & rx_sync);
`else
    assign decide  = (cnt == CNT_MID);
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE:   if (fall) state_d = S_START;
            S_START: begin
                if (decide && bit_val) state_d = S_IDLE;
                else if (bit_end)      state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == DATA_LAST)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (decide && bit_idx == STOP_LAST) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        par_bad = 1'b0;
        if (PARITY == 2)      par_bad = (par_bit != ^shreg);
        else if (PARITY == 1) par_bad = (par_bit != ~^shreg);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            if (state_q == S_IDLE || state_d != state_q || bit_end) cnt <= '0;
            else                                                     cnt <= cnt + 1'b1;

            if (state_d != state_q) bit_idx <= '0;
            else if (bit_end)       bit_idx <= bit_idx + 1'b1;

            if (state_q == S_DATA && decide)   shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state_q == S_PARITY && decide) par_bit <= bit_val;

            if (state_q == S_START)                         stop_bad <= 1'b0;
            else if (state_q == S_STOP && decide && !bit_val) stop_bad <= 1'b1;
        end
    end

    // Error flags live only in the data_valid cycle; data_out holds until the next frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= done;
            if (done) begin
                data_out   <= shreg;
                parity_err <= par_bad;
                frame_err  <= stop_bad | ~bit_val;
            end else begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 8N2) driven by one clock/reset.
// Channel 0 is 8N1, channel 1 is even parity, channel 2 has two stop bits.
module tb_uart_rx_param;

    localparam int BAUD_DIV = 50_000_000 / 115200;  // 434

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [7:0] dout [3];
    logic [2:0] dv, perr, ferr, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   dv_cnt [3] = '{0, 0, 0};
    logic [7:0] cap_d  [3];
    logic       cap_pe [3];
    logic       cap_fe [3];

    always #10 sys_clk = ~sys_clk;

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx(rx_line[0]), .data_out(dout[0]),
        .data_valid(dv[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));

    uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx(rx_line[1]), .data_out(dout[1]),
        .data_valid(dv[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx(rx_line[2]), .data_out(dout[2]),
        .data_valid(dv[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));

    // Each high cycle of data_valid counts, so a stretched pulse shows up as an extra count.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k]) begin
                dv_cnt[k] = dv_cnt[k] + 1;
                cap_d[k]  = dout[k];
                cap_pe[k] = perr[k];
                cap_fe[k] = ferr[k];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input int ch, input logic b);
        rx_line[ch] = b;
        repeat (BAUD_DIV) @(negedge sys_clk);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input int npar,
                              input logic pbit, input logic [1:0] stops, input int nstop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, d[i]);
        if (npar != 0) send_bit(ch, pbit);
        for (int i = 0; i < nstop; i++) send_bit(ch, stops[i]);
    endtask

    task automatic idle(input int cycles);
        rx_line = 3'b111;
        repeat (cycles) @(negedge sys_clk);
    endtask

    initial begin
        repeat (5) @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_dout", 32'(dout[k]), 32'h0);
            check("reset_dv",   32'(dv[k]),   32'h0);
            check("reset_perr", 32'(perr[k]), 32'h0);
            check("reset_ferr", 32'(ferr[k]), 32'h0);
            check("reset_busy", 32'(busy[k]), 32'h0);
        end
        rst_n = 1'b1;
        idle(20);

        // 8N1 0x55
        send_frame(0, 8'h55, 0, 1'b0, 2'b11, 1);
        check("n1_55_count", 32'(dv_cnt[0]), 32'd1);
        check("n1_55_data",  32'(cap_d[0]),  32'h55);
        check("n1_55_perr",  32'(cap_pe[0]), 32'h0);
        check("n1_55_ferr",  32'(cap_fe[0]), 32'h0);
        check("n1_55_busy",  32'(busy[0]),   32'h0);
        idle(50);

        // False start: 150 low cycles is shorter than half a bit
        rx_line[0] = 1'b0;
        repeat (100) @(negedge sys_clk);
        check("false_busy_hi", 32'(busy[0]), 32'h1);
        repeat (50) @(negedge sys_clk);
        idle(2 * BAUD_DIV);
        check("false_no_dv",   32'(dv_cnt[0]), 32'd1);
        check("false_busy_lo", 32'(busy[0]),   32'h0);
        check("false_hold",    32'(dout[0]),   32'h55);
        send_frame(0, 8'h81, 0, 1'b0, 2'b11, 1);
        check("after_false_count", 32'(dv_cnt[0]), 32'd2);
        check("after_false_data",  32'(cap_d[0]),  32'h81);
        idle(50);

        // Back-to-back frames with no idle between them
        send_frame(0, 8'h00, 0, 1'b0, 2'b11, 1);
        check("b2b_first_count", 32'(dv_cnt[0]), 32'd3);
        check("b2b_first_data",  32'(cap_d[0]),  32'h00);
        send_frame(0, 8'hFF, 0, 1'b0, 2'b11, 1);
        check("b2b_second_count", 32'(dv_cnt[0]), 32'd4);
        check("b2b_second_data",  32'(cap_d[0]),  32'hFF);
        check("b2b_errs", 32'({cap_pe[0], cap_fe[0]}), 32'h0);
        idle(50);

        // Reset during bit 4 of 0x5A
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, (8'h5A >> i) & 8'h1);
        rx_line[0] = 1'b1;
        repeat (200) @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("rst_mid_dout", 32'(dout[0]), 32'h0);
        check("rst_mid_busy", 32'(busy[0]), 32'h0);
        rst_n = 1'b1;
        idle(12 * BAUD_DIV);
        check("rst_mid_no_dv", 32'(dv_cnt[0]), 32'd4);
        check("rst_mid_idle",  32'(busy[0]),   32'h0);
        send_frame(0, 8'h5A, 0, 1'b0, 2'b11, 1);
        check("after_rst_count", 32'(dv_cnt[0]), 32'd5);
        check("after_rst_data",  32'(cap_d[0]),  32'h5A);
        idle(50);

        // Even parity: 0xA5 has four ones, so the correct parity bit is 0
        send_frame(1, 8'hA5, 1, 1'b1, 2'b11, 1);
        check("par_bad_count", 32'(dv_cnt[1]), 32'd1);
        check("par_bad_data",  32'(cap_d[1]),  32'hA5);
        check("par_bad_perr",  32'(cap_pe[1]), 32'h1);
        check("par_bad_ferr",  32'(cap_fe[1]), 32'h0);
        check("par_err_clear", 32'(perr[1]),   32'h0);
        idle(50);
        send_frame(1, 8'hA5, 1, 1'b0, 2'b11, 1);
        check("par_ok_count", 32'(dv_cnt[1]), 32'd2);
        check("par_ok_perr",  32'(cap_pe[1]), 32'h0);
        idle(50);

        // Two stop bits, second one low
        send_frame(2, 8'h3C, 0, 1'b0, 2'b01, 2);
        check("stop2_count", 32'(dv_cnt[2]), 32'd1);
        check("stop2_data",  32'(cap_d[2]),  32'h3C);
        check("stop2_ferr",  32'(cap_fe[2]), 32'h1);
        check("stop2_clear", 32'(ferr[2]),   32'h0);
        idle(50);
        send_frame(2, 8'hC3, 0, 1'b0, 2'b11, 2);
        check("stop2_ok_data", 32'(cap_d[2]),  32'hC3);
        check("stop2_ok_ferr", 32'(cap_fe[2]), 32'h0);
        idle(50);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted glitch near each mid-sample of 0xF0
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hF0, 1'b0};
            for (int i = 0; i < 10; i++) begin
                rx_line[0] = bits[i];
                repeat (BAUD_DIV / 2 + 2) @(negedge sys_clk);
                rx_line[0] = ~bits[i];
                @(negedge sys_clk);
                rx_line[0] = bits[i];
                repeat (BAUD_DIV - BAUD_DIV / 2 - 3) @(negedge sys_clk);
            end
        end
        check("maj_count", 32'(dv_cnt[0]), 32'd6);
        check("maj_data",  32'(cap_d[0]),  32'hF0);
        check("maj_ferr",  32'(cap_fe[0]), 32'h0);
        idle(50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
